magia_stdio_line_arbiter: RTL and testbench

//  Collects per-tile stdout characters (one byte per write to the tile's stdio slot 0xFFFF0004+4*hartid)

---
 rtl/magia_stdio_line_arbiter.sv | 133 +++++++++++++
 tb/tb_magia_stdio_line_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/magia_stdio_line_arbiter.sv
// magia_stdio_line_arbiter: gathers per-tile stdout bytes into line buffers and
// emits complete lines one at a time, round-robin, on a single byte stream.
//   clk_i, rst_ni           clock, async active-low reset (release synchronised upstream)
//   char_valid_i/data_i     per-tile byte write, tile t on char_data_i[8t+7:8t]
//   char_ready_o            per-tile accept (buffer open and not full)
//   flush_i                 close every open non-empty line
//   out_valid_o/ready_i     output byte handshake
//   out_data_o, out_tile_o  output byte and its source tile
//   out_last_o, out_trunc_o final byte of line, line closed by a full buffer
//   busy_o                  any buffered data or drain in progress
module magia_stdio_line_arbiter #(
    parameter int N_TILES    = 4,
    parameter int LINE_DEPTH = 16,
    parameter int TID_W      = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_TILES-1:0]   char_valid_i,
    input  logic [N_TILES*8-1:0] char_data_i,
    output logic [N_TILES-1:0]   char_ready_o,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    output logic [7:0]           out_data_o,
    output logic [TID_W-1:0]     out_tile_o,
    output logic                 out_last_o,
    output logic                 out_trunc_o,
    input  logic                 out_ready_i,
    output logic                 busy_o
);
    localparam int CNT_W = $clog2(LINE_DEPTH + 1);
    localparam int IDX_W = $clog2(LINE_DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(LINE_DEPTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_DEPTH - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                          r_state, w_state_nx;
    logic [TID_W-1:0]                r_gnt, r_rr, w_pick, w_cand;
    logic [IDX_W-1:0]                r_rd;
    logic                            r_gtrunc, w_found, w_hs;
    logic [N_TILES-1:0]              w_closed, w_trunc;
    logic [N_TILES-1:0][CNT_W-1:0]   w_cnt;
    logic [N_TILES-1:0][7:0]         w_byte;

    for (genvar t = 0; t < N_TILES; t++) begin : g_tile
        logic [7:0]       r_buf [LINE_DEPTH];
        logic [CNT_W-1:0] r_cnt;
        logic             r_closed, r_trunc;
        logic [7:0]       w_ch;
        logic             w_acc, w_nl, w_done;
        assign w_ch            = char_data_i[8*t +: 8];
        assign char_ready_o[t] = !r_closed && r_cnt != FULL;
        assign w_acc           = char_valid_i[t] && char_ready_o[t];
        assign w_nl            = w_ch == 8'h0A;
        assign w_done          = w_hs && out_last_o && r_gnt == TID_W'(t);
        assign w_closed[t]     = r_closed;
        assign w_trunc[t]      = r_trunc;
        assign w_cnt[t]        = r_cnt;
        assign w_byte[t]       = r_buf[r_rd];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt    <= '0;
                r_closed <= 1'b0;
                r_trunc  <= 1'b0;
            end else if (w_done) begin
                r_cnt    <= '0;
                r_closed <= 1'b0;
            end else begin
                if (w_acc) r_cnt <= r_cnt + CNT_W'(1);
                // a newline wins over a simultaneous fill, so that line is not truncated
                if (w_acc && (w_nl || r_cnt == LAST)) begin
                    r_closed <= 1'b1;
                    r_trunc  <= !w_nl;
                end else if (flush_i && !r_closed && (w_acc || r_cnt != '0)) begin
                    r_closed <= 1'b1;
                    r_trunc  <= 1'b0;
                end
            end
        end
        always_ff @(posedge clk_i) begin
            if (w_acc) r_buf[r_cnt[IDX_W-1:0]] <= w_ch;
        end
    end

    // first closed tile at or after the round-robin pointer; scanning downward
    // leaves the nearest candidate as the final assignment
    always_comb begin
        w_pick  = r_rr;
        w_cand  = r_rr;
        w_found = 1'b0;
        for (int i = N_TILES - 1; i >= 0; i--) begin
            w_cand = TID_W'((int'(r_rr) + i) % N_TILES);
            if (w_closed[w_cand]) begin
                w_pick  = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign out_valid_o = r_state == DRAIN;
    assign out_data_o  = out_valid_o ? w_byte[r_gnt] : 8'h00;
    assign out_tile_o  = out_valid_o ? r_gnt : '0;
    assign out_last_o  = out_valid_o && (CNT_W'(r_rd) + CNT_W'(1) == w_cnt[r_gnt]);
    assign out_trunc_o = out_valid_o && r_gtrunc;
    assign w_hs        = out_valid_o && out_ready_i;
    assign busy_o      = (|w_cnt) || r_state != IDLE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_rr     <= '0;
            r_rd     <= '0;
            r_gtrunc <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == IDLE && w_found) begin
                r_gnt    <= w_pick;
                r_gtrunc <= w_trunc[w_pick];
                r_rd     <= '0;
            end else if (w_hs) begin
                r_rd <= r_rd + IDX_W'(1);
                if (out_last_o) r_rr <= (r_gnt == TID_W'(N_TILES - 1)) ? '0 : r_gnt + TID_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (r_state == IDLE && w_found) w_state_nx = DRAIN;
        else if (w_hs && out_last_o) w_state_nx = IDLE;
    end
endmodule

// File: tb/tb_magia_stdio_line_arbiter.sv
// tb_magia_stdio_line_arbiter: directed line vectors plus multi-cycle corner sequences
module tb_magia_stdio_line_arbiter;
    localparam int N = 4;

    logic           clk_i = 1'b0, rst_ni = 1'b0;
    logic [N-1:0]   char_valid_i = '0;
    logic [N*8-1:0] char_data_i = '0;
    logic [N-1:0]   char_ready_o;
    logic           flush_i = 1'b0, out_ready_i = 1'b1;
    logic           out_valid_o, out_last_o, out_trunc_o, busy_o;
    logic [7:0]     out_data_o;
    logic [1:0]     out_tile_o;

    int n_cmp = 0, n_err = 0;

    typedef struct packed {
        logic [1:0] tile;
        logic [7:0] data;
        logic       last;
        logic       trunc;
    } beat_t;

    typedef struct {
        int tile;
        int len;
        bit nl;
        bit fl;
        bit trunc;
    } vec_t;

    beat_t      q[$];
    logic [7:0] eb[$];
    vec_t       tab[6];

    always #5 clk_i = ~clk_i;

    magia_stdio_line_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .char_valid_i(char_valid_i), .char_data_i(char_data_i),
        .char_ready_o(char_ready_o), .flush_i(flush_i), .out_valid_o(out_valid_o),
        .out_data_o(out_data_o), .out_tile_o(out_tile_o), .out_last_o(out_last_o),
        .out_trunc_o(out_trunc_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
    );

    always @(negedge clk_i)
        if (rst_ni && out_valid_o && out_ready_i)
            q.push_back({out_tile_o, out_data_o, out_last_o, out_trunc_o});

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        char_valid_i = '0;
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        step();
        step();
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        q.delete();
    endtask

    task automatic put(input int t, input logic [7:0] d);
        int w = 0;
        char_data_i[8*t +: 8] = d;
        char_valid_i[t] = 1'b1;
        while (!char_ready_o[t] && w < 200) begin
            step();
            w++;
        end
        if (w >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL put tile %0d: ready never rose", t);
        end
        step();
        char_valid_i[t] = 1'b0;
    endtask

    task automatic wait_q(input int n, input string nm);
        int w = 0;
        while (q.size() < n && w < 500) begin
            step();
            w++;
        end
        if (q.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: got %0d beats expected %0d", nm, q.size(), n);
        end
    endtask

    task automatic wait_idle(input string nm);
        int w = 0;
        while (busy_o && w < 500) begin
            step();
            w++;
        end
        chk({nm, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    task automatic expect_line(input int t, input logic tr, input string nm);
        beat_t g, e;
        wait_q(eb.size(), nm);
        foreach (eb[i]) begin
            if (q.size() == 0) return;
            g = q.pop_front();
            e.tile  = 2'(t);
            e.data  = eb[i];
            e.last  = (i == eb.size() - 1);
            e.trunc = tr;
            chk($sformatf("%s[%0d]", nm, i), 32'(g), 32'(e));
        end
    endtask

    task automatic set2(input logic [7:0] a, input logic [7:0] b);
        eb.delete();
        eb.push_back(a);
        eb.push_back(b);
    endtask

    task automatic put_multi(input logic [N-1:0] m, input logic [7:0] d);
        for (int t = 0; t < N; t++) if (m[t]) char_data_i[8*t +: 8] = d;
        char_valid_i = m;
        step();
        char_valid_i = '0;
    endtask

    initial begin
        tab[0] = '{1, 16, 1'b0, 1'b0, 1'b1};
        tab[1] = '{3, 2, 1'b0, 1'b1, 1'b0};
        tab[2] = '{0, 16, 1'b1, 1'b0, 1'b0};
        tab[3] = '{2, 1, 1'b1, 1'b0, 1'b0};
        tab[4] = '{0, 5, 1'b1, 1'b0, 1'b0};
        tab[5] = '{2, 1, 1'b0, 1'b1, 1'b0};

        #1;
        chk("reset_outs", {out_valid_o, out_data_o, out_tile_o, out_last_o, out_trunc_o, busy_o}, '0);
        chk("reset_ready", 32'(char_ready_o), 32'hF);
        do_reset();

        // single line, exact first-byte latency and ready release
        put(2, 8'h68);
        put(2, 8'h69);
        put(2, 8'h0A);
        chk("t1_not_yet", 32'(out_valid_o), 32'd0);
        chk("t1_stall", 32'(char_ready_o[2]), 32'd0);
        step();
        chk("t1_b0", {out_valid_o, out_tile_o, out_data_o, out_last_o}, {1'b1, 2'd2, 8'h68, 1'b0});
        step();
        chk("t1_b1", {out_valid_o, out_tile_o, out_data_o, out_last_o}, {1'b1, 2'd2, 8'h69, 1'b0});
        step();
        chk("t1_b2", {out_valid_o, out_tile_o, out_data_o, out_last_o}, {1'b1, 2'd2, 8'h0A, 1'b1});
        step();
        chk("t1_gap", 32'(out_valid_o), 32'd0);
        chk("t1_ready_back", 32'(char_ready_o[2]), 32'd1);
        eb.delete();
        eb.push_back(8'h68);
        eb.push_back(8'h69);
        eb.push_back(8'h0A);
        expect_line(2, 1'b0, "t1");

        foreach (tab[v]) begin
            eb.delete();
            for (int i = 0; i < tab[v].len; i++)
                eb.push_back((tab[v].nl && i == tab[v].len - 1) ? 8'h0A : 8'(8'h61 + i));
            foreach (eb[i]) put(tab[v].tile, eb[i]);
            if (tab[v].fl) begin
                flush_i = 1'b1;
                step();
                flush_i = 1'b0;
            end
            chk($sformatf("v%0d_stalled", v), 32'(char_ready_o[tab[v].tile]), 32'd0);
            expect_line(tab[v].tile, tab[v].trunc, $sformatf("v%0d", v));
            wait_idle($sformatf("v%0d", v));
            chk($sformatf("v%0d_extra", v), 32'(q.size()), 32'd0);
        end

        // round-robin order from a fresh pointer, then from pointer 1
        do_reset();
        put_multi(4'b1011, 8'h41);
        put_multi(4'b1011, 8'h0A);
        set2(8'h41, 8'h0A);
        expect_line(0, 1'b0, "t2_a");
        expect_line(1, 1'b0, "t2_b");
        expect_line(3, 1'b0, "t2_c");
        put(0, 8'h58);
        put(0, 8'h0A);
        set2(8'h58, 8'h0A);
        expect_line(0, 1'b0, "t2_x");
        wait_idle("t2_x");
        for (int t = 0; t < 2; t++) char_data_i[8*t +: 8] = (t == 0) ? 8'h42 : 8'h43;
        char_valid_i = 4'b0011;
        step();
        char_data_i[15:0] = 16'h0A0A;
        step();
        char_valid_i = '0;
        set2(8'h43, 8'h0A);
        expect_line(1, 1'b0, "t2_rr1");
        set2(8'h42, 8'h0A);
        expect_line(0, 1'b0, "t2_rr0");
        wait_idle("t2");

        // flush coinciding with an accepted byte, and flush with nothing buffered
        put(0, 8'h61);
        char_data_i[7:0] = 8'h62;
        char_valid_i[0] = 1'b1;
        flush_i = 1'b1;
        step();
        char_valid_i[0] = 1'b0;
        flush_i = 1'b0;
        set2(8'h61, 8'h62);
        expect_line(0, 1'b0, "flush_edge");
        wait_idle("flush_edge");
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        repeat (4) step();
        chk("flush_empty_beats", 32'(q.size()), 32'd0);
        chk("flush_empty_busy", 32'(busy_o), 32'd0);

        // sink backpressure mid-line while another tile writes
        eb.delete();
        for (int i = 0; i < 7; i++) eb.push_back(8'(8'h30 + i));
        eb.push_back(8'h0A);
        foreach (eb[i]) put(2, eb[i]);
        wait_q(3, "t5_start");
        out_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t5_hold%0d", c), {out_valid_o, out_tile_o, out_data_o, out_last_o},
                {1'b1, 2'd2, 8'h33, 1'b0});
            char_valid_i[0] = (c < 2);
            char_data_i[7:0] = (c == 0) ? 8'h51 : 8'h0A;
            if (c < 2) chk($sformatf("t5_rdy%0d", c), 32'(char_ready_o[0]), 32'd1);
            step();
        end
        char_valid_i[0] = 1'b0;
        out_ready_i = 1'b1;
        expect_line(2, 1'b0, "t5_line");
        set2(8'h51, 8'h0A);
        expect_line(0, 1'b0, "t5_other");
        wait_idle("t5");

        // reset in the middle of a drain discards everything
        eb.delete();
        for (int i = 0; i < 9; i++) eb.push_back(8'(8'h61 + i));
        eb.push_back(8'h0A);
        foreach (eb[i]) put(1, eb[i]);
        wait_q(3, "t6_start");
        rst_ni = 1'b0;
        #1;
        chk("t6_outs", {out_valid_o, out_data_o, out_tile_o, out_last_o, out_trunc_o, busy_o}, '0);
        chk("t6_ready", 32'(char_ready_o), 32'hF);
        step();
        step();
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (20) step();
        chk("t6_no_more", 32'(q.size()), 32'd3);
        chk("t6_idle", {out_valid_o, busy_o}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
